// File: rtl/cam_capture_ctrl.sv
// Camera capture front end: re-times the sensor's VSYNC/HREF/Y8 stream, discards
// a configurable number of warm-up frames and forwards windowed pixels to a frame buffer.
module cam_capture_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        PIXCLK,
  input  logic        irst_n,
  input  logic        i_cfg_done,
  input  logic        i_enable,
  input  logic        VSYNC,
  input  logic        HREF,
  input  logic [7:0]  i_pix,
  input  logic        i_fifo_full,
  input  logic        i_clr_err,
  output logic        o_vs_n,
  output logic        o_de,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic [7:0]  o_frame_cnt,
  output logic        o_err_line,
  output logic        o_overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, ACTIVE} state_t;

  localparam int              CW    = 12;
  localparam int              SKW   = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [CW-1:0]   CMAX  = '1;
  localparam logic [CW-1:0]   H_LIM = CW'(H_RES);
  localparam logic [CW-1:0]   V_LIM = CW'(V_RES);

  logic           vs_s1, vs_s2, hs_s1, hs_s2;
  logic [7:0]     pix_s1;
  state_t         state_q, state_d;
  logic [SKW-1:0] skip_q, skip_d;
  logic [CW-1:0]  col_q, col_d, col_idx, row_q, row_d;
  logic           hold_q, hold_d;
  logic           vs_rise, hs_rise, hs_fall;
  logic           act, in_win, de_d, err_set, ovf_set, frame_inc, fwd;

  assign vs_rise = vs_s1 & ~vs_s2;
  assign hs_rise = hs_s1 & ~hs_s2;
  assign hs_fall = ~hs_s1 & hs_s2;

  // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    frame_inc = 1'b0;
    if (!i_cfg_done) begin
      state_d = IDLE;
      skip_d  = '0;
    end else begin
      unique case (state_q)
        IDLE:    if (i_enable) state_d = WAIT_VS;
        WAIT_VS: begin
          if (!i_enable) begin
            state_d = IDLE;
          end else if (vs_rise) begin
            if (SKIP_FRAMES == 0) begin
              state_d = ACTIVE;
            end else begin
              state_d = SKIP;
              skip_d  = SKW'(SKIP_FRAMES);
            end
          end
        end
        SKIP: begin
          if (!i_enable) begin
            state_d = IDLE;
            skip_d  = '0;
          end else if (vs_rise) begin
            skip_d = skip_q - SKW'(1);
            if (skip_q == SKW'(1)) state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_inc = 1'b1;
            if (!i_enable) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The first HREF-high cycle is column 0, so the rising edge indexes from zero directly.
  always_comb begin
    col_idx = hs_rise ? '0 : col_q;
    col_d   = col_q;
    row_d   = row_q;
    if (hs_s1) col_d = (col_idx == CMAX) ? CMAX : col_idx + CW'(1);
    if (vs_rise) begin
      row_d = '0;
    end else if (hs_fall && row_q != CMAX) begin
      row_d = row_q + CW'(1);
    end
    if (!i_cfg_done) begin
      col_d = '0;
      row_d = '0;
    end
  end

  // Forwarding window and error events; row_q is the index of the line currently in S1.
  always_comb begin
    act     = (state_q == ACTIVE) && i_cfg_done;
    in_win  = act && hs_s1 && (col_idx < H_LIM) && (row_q < V_LIM);
    de_d    = in_win && !i_fifo_full;
    ovf_set = in_win && i_fifo_full;
    err_set = act && hs_fall && ((col_q != H_LIM) || (row_q == V_LIM));
    // The opening pulse and the whole terminating pulse are passed through to the buffer.
    fwd     = i_cfg_done && ((state_q == ACTIVE) || (state_d == ACTIVE) || hold_q);
    hold_d  = i_cfg_done && vs_s1 && (hold_q || ((state_q == ACTIVE) && (state_d != ACTIVE)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PIXCLK or negedge irst_n) begin
    if (!irst_n) begin
      vs_s1       <= 1'b0;
      vs_s2       <= 1'b0;
      hs_s1       <= 1'b0;
      hs_s2       <= 1'b0;
      pix_s1      <= '0;
      state_q     <= IDLE;
      skip_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= 1'b0;
      o_vs_n      <= 1'b1;
      o_de        <= 1'b0;
      o_data      <= '0;
      o_busy      <= 1'b0;
      o_frame_cnt <= '0;
      o_err_line  <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      vs_s1   <= VSYNC;
      vs_s2   <= vs_s1;
      hs_s1   <= HREF;
      hs_s2   <= hs_s1;
      pix_s1  <= i_pix;
      state_q <= state_d;
      skip_q  <= skip_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      o_vs_n  <= ~(vs_s1 && fwd);
      o_de    <= de_d;
      o_data  <= de_d ? {8'd0, pix_s1} : 16'd0;
      o_busy  <= (state_d == SKIP) || (state_d == ACTIVE);
      if (frame_inc) o_frame_cnt <= o_frame_cnt + 8'd1;
      if (err_set) begin
        o_err_line <= 1'b1;
      end else if (i_clr_err) begin
        o_err_line <= 1'b0;
      end
      if (ovf_set) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule
